// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the counter_sched round-robin step scheduler.
package counter_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        CLEAR  = 2'd2
    } state_e;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

endpackage

// File: rtl/counter_sched_rr_arb.sv
// Combinational round-robin arbiter: first eligible requester at or after ptr wins.
module rr_arb #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] ptr_nxt
);

    int            idx;
    logic [PW-1:0] sel;
    logic          found;

    always_comb begin
        grant   = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) idx = idx - N;
            sel = PW'(idx);
            if (!found && eligible[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                ptr_nxt    = (idx == N - 1) ? '0 : PW'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one saturating up/down counter among NUM_REQ requesters.
// Optional watermark interrupt (hi_wm, lo_wm, wm_irq) enabled by COUNTER_SCHED_WATERMARK_EN.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 4,
    parameter int MAX_VAL = 2**WIDTH - 1
) (
    input  logic               clk,
    input  logic               rst,
`ifdef COUNTER_SCHED_WATERMARK_EN
    input  logic [WIDTH-1:0]   hi_wm,
    input  logic [WIDTH-1:0]   lo_wm,
    output logic               wm_irq,
`endif
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_dir,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic               clr,
    output logic [WIDTH-1:0]   count,
    output logic               busy,
    output logic               at_max,
    output logic               at_zero
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    state_e             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d, ptr_arb;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               at_max_q, at_max_d;
    logic               at_zero_q, at_zero_d;
    logic [NUM_REQ-1:0] eligible, grant;
    logic               inc_ok, dec_ok;

    // Saturation is enforced purely by masking illegal steps out of arbitration.
    always_comb begin
        inc_ok = count_q < MAX_C;
        dec_ok = count_q != '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] & ((req_dir[i] == DIR_DEC) ? dec_ok : inc_ok);
        end
    end

    rr_arb #(.N(NUM_REQ)) u_arb (
        .eligible (eligible),
        .ptr      (ptr_q),
        .grant    (grant),
        .ptr_nxt  (ptr_arb)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        req_ready = '0;
        case (state_q)
            CLEAR: begin
                count_d = '0;
                state_d = clr ? CLEAR : IDLE;
            end
            default: begin
                if (clr) begin
                    state_d = CLEAR;
                end else if (|eligible) begin
                    state_d   = ACTIVE;
                    req_ready = grant;
                    ptr_d     = ptr_arb;
                    count_d   = ((grant & req_dir) != '0) ? count_q + WIDTH'(1)
                                                          : count_q - WIDTH'(1);
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
        if (rst) req_ready = '0;
        at_max_d  = count_d == MAX_C;
        at_zero_d = count_d == '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            count_q   <= '0;
            at_max_q  <= 1'b0;
            at_zero_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            at_max_q  <= at_max_d;
            at_zero_q <= at_zero_d;
        end
    end

`ifdef COUNTER_SCHED_WATERMARK_EN
    logic wm_irq_q, wm_irq_d;

    // A clear forces count to zero but must not look like a downward crossing.
    always_comb begin
        wm_irq_d = (state_q != CLEAR) &&
                   (((count_d >= hi_wm) && (count_q < hi_wm)) ||
                    ((count_d <= lo_wm) && (count_q > lo_wm)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wm_irq_q <= 1'b0;
        else     wm_irq_q <= wm_irq_d;
    end

    assign wm_irq = wm_irq_q;
`endif

    assign count   = count_q;
    assign at_max  = at_max_q;
    assign at_zero = at_zero_q;
    assign busy    = state_q == CLEAR;

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched (WIDTH=4, MAX_VAL=10) with a behavioural model.
module tb_counter_sched;

    localparam int MAXV = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_valid = '0;
    logic [3:0] req_dir = '0;
    logic [3:0] req_ready;
    logic       clr = 1'b0;
    logic [3:0] count;
    logic       busy, at_max, at_zero;
`ifdef COUNTER_SCHED_WATERMARK_EN
    logic [3:0] hi_wm = 4'd15;
    logic [3:0] lo_wm = 4'd0;
    logic       wm_irq;
`endif

    int errors = 0;
    int checks = 0;

    int m_count = 0;
    int m_ptr = 0;
    bit m_clear = 1'b0;

    counter_sched #(.WIDTH(4), .NUM_REQ(4), .MAX_VAL(MAXV)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef COUNTER_SCHED_WATERMARK_EN
        .hi_wm     (hi_wm),
        .lo_wm     (lo_wm),
        .wm_irq    (wm_irq),
`endif
        .req_valid (req_valid),
        .req_dir   (req_dir),
        .req_ready (req_ready),
        .clr       (clr),
        .count     (count),
        .busy      (busy),
        .at_max    (at_max),
        .at_zero   (at_zero)
    );

    always #5 clk = ~clk;

    // Which requester the scheduler should grant this cycle, from the rules.
    function automatic logic [3:0] m_grant(input logic [3:0] v, input logic [3:0] d, input logic c);
        if (m_clear || c) return 4'b0000;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (v[i] && (d[i] ? (m_count < MAXV) : (m_count > 0))) begin
                logic [3:0] g;
                g = 4'b0000;
                g[i] = 1'b1;
                return g;
            end
        end
        return 4'b0000;
    endfunction

    task automatic m_commit();
        logic [3:0] g;
        g = m_grant(req_valid, req_dir, clr);
        if (m_clear) begin
            m_count = 0;
            m_clear = clr;
        end else if (clr) begin
            m_clear = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (g[i]) begin
                    m_count = m_count + (req_dir[i] ? 1 : -1);
                    m_ptr   = (i + 1) % 4;
                end
            end
        end
    endtask

    task automatic m_reset();
        m_count = 0;
        m_ptr   = 0;
        m_clear = 1'b0;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic advance();
        m_commit();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        req_dir   = 4'hF;
        @(negedge clk);
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (at_zero !== 1'b1) begin errors++; $display("FAIL reset_at_zero got=%b exp=1", at_zero); end
        checks++; if (at_max !== 1'b0) begin errors++; $display("FAIL reset_at_max got=%b exp=0", at_max); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef COUNTER_SCHED_WATERMARK_EN
        checks++; if (wm_irq !== 1'b0) begin errors++; $display("FAIL reset_wm_irq got=%b exp=0", wm_irq); end
`endif
        req_valid = '0;
        req_dir   = '0;
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        req_dir   = 4'b0100;
        for (int k = 1; k <= 5; k++) begin
            #1;
            checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready step=%0d got=%b exp=0100", k, req_ready); end
            advance();
            checks++; if (count !== 4'(k)) begin errors++; $display("FAIL single_count got=%0d exp=%0d", count, k); end
            checks++; if (at_zero !== 1'b0) begin errors++; $display("FAIL single_at_zero step=%0d got=%b exp=0", k, at_zero); end
        end
        req_valid = '0;
    endtask

    task automatic test_rotate();
        int gcnt[4];
        logic [3:0] exp;
        do_reset();
        for (int i = 0; i < 4; i++) gcnt[i] = 0;
        req_valid = 4'hF;
        req_dir   = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp = 4'b0001 << (k % 4);
            checks++; if (req_ready !== exp) begin errors++; $display("FAIL rotate_ready cycle=%0d got=%b exp=%b", k, req_ready, exp); end
            for (int i = 0; i < 4; i++) if (req_ready[i] === 1'b1) gcnt[i]++;
            advance();
        end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL rotate_count got=%0d exp=8", count); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (gcnt[i] != 2) begin errors++; $display("FAIL rotate_grants req=%0d got=%0d exp=2", i, gcnt[i]); end
        end
        req_valid = '0;
    endtask

    task automatic test_saturate();
        do_reset();
        req_valid = 4'b0001;
        req_dir   = 4'b0001;
        for (int k = 0; k < MAXV; k++) advance();
        checks++; if (count !== 4'(MAXV)) begin errors++; $display("FAIL sat_fill_count got=%0d exp=%0d", count, MAXV); end
        checks++; if (at_max !== 1'b1) begin errors++; $display("FAIL sat_at_max got=%b exp=1", at_max); end
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL sat_inc_blocked got=%b exp=0000", req_ready); end
        req_valid = 4'b0011;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL sat_dec_ready got=%b exp=0010", req_ready); end
        advance();
        checks++; if (count !== 4'd9) begin errors++; $display("FAIL sat_dec_count got=%0d exp=9", count); end
        checks++; if (at_max !== 1'b0) begin errors++; $display("FAIL sat_at_max_drop got=%b exp=0", at_max); end
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL sat_inc_ready got=%b exp=0001", req_ready); end
        advance();
        checks++; if (count !== 4'd10) begin errors++; $display("FAIL sat_inc_count got=%0d exp=10", count); end
        req_valid = '0;
    endtask

    task automatic test_zero();
        do_reset();
        req_valid = 4'b1000;
        req_dir   = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL zero_blocked cycle=%0d got=%b exp=0000", k, req_ready); end
            advance();
            checks++; if (count !== 4'd0) begin errors++; $display("FAIL zero_count cycle=%0d got=%0d exp=0", k, count); end
        end
        req_valid = 4'b1010;
        req_dir   = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL zero_inc_ready got=%b exp=0010", req_ready); end
        advance();
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL zero_inc_count got=%0d exp=1", count); end
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL zero_dec_ready got=%b exp=1000", req_ready); end
        advance();
        checks++; if (count !== 4'd0 || at_zero !== 1'b1) begin errors++; $display("FAIL zero_dec_count got=%0d/%b exp=0/1", count, at_zero); end
        req_valid = '0;
    endtask

    task automatic test_clear();
        do_reset();
        req_valid = 4'b0001;
        req_dir   = 4'b0001;
        for (int k = 0; k < 7; k++) advance();
        checks++; if (count !== 4'd7) begin errors++; $display("FAIL clr_pre_count got=%0d exp=7", count); end
        clr = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL clr_same_cycle_ready got=%b exp=0000", req_ready); end
        advance();
        clr = 1'b0;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy got=%b exp=1", busy); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL clr_state_ready got=%b exp=0000", req_ready); end
        checks++; if (count !== 4'd7) begin errors++; $display("FAIL clr_hold_count got=%0d exp=7", count); end
        advance();
        #1;
        checks++; if (count !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL clr_done count=%0d busy=%b exp=0/0", count, busy); end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL clr_resume_ready got=%b exp=0001", req_ready); end
        advance();
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL clr_resume_count got=%0d exp=1", count); end
        req_valid = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req_valid = 4'b0001;
        req_dir   = 4'b0001;
        for (int k = 0; k < 3; k++) advance();
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL arst_pre_count got=%0d exp=3", count); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (count !== 4'd0 || at_zero !== 1'b1) begin errors++; $display("FAIL arst_count got=%0d/%b exp=0/1", count, at_zero); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL arst_ready got=%b exp=0000", req_ready); end
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        req_valid = 4'b1010;
        req_dir   = 4'b1010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL arst_rearb_ready got=%b exp=0010", req_ready); end
        advance();
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL arst_rearb_count got=%0d exp=1", count); end
        req_valid = '0;
    endtask

`ifdef COUNTER_SCHED_WATERMARK_EN
    task automatic test_watermark();
        do_reset();
        hi_wm = 4'd4;
        lo_wm = 4'd0;
        req_valid = 4'b0001;
        req_dir   = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            advance();
            checks++; if (wm_irq !== (k == 4)) begin errors++; $display("FAIL wm_hi count=%0d got=%b exp=%b", k, wm_irq, k == 4); end
        end
        req_valid = '0;
        clr = 1'b1;
        advance();
        clr = 1'b0;
        advance();
        checks++; if (count !== 4'd0 || wm_irq !== 1'b0) begin errors++; $display("FAIL wm_clr count=%0d irq=%b exp=0/0", count, wm_irq); end
        hi_wm = 4'd15;
    endtask
`endif

    task automatic test_random();
        logic [3:0] prev_g;
        logic [3:0] exp;
        do_reset();
        prev_g = '0;
        req_valid = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] || prev_g[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_dir[i]   = 1'($urandom_range(0, 1));
                end
            end
            clr = ($urandom_range(0, 24) == 0);
            #1;
            exp = m_grant(req_valid, req_dir, clr);
            prev_g = exp;
            checks++; if (req_ready !== exp) begin errors++; $display("FAIL rand_ready cycle=%0d got=%b exp=%b", c, req_ready, exp); end
            advance();
            checks++; if (count !== 4'(m_count)) begin errors++; $display("FAIL rand_count cycle=%0d got=%0d exp=%0d", c, count, m_count); end
            checks++; if (busy !== m_clear) begin errors++; $display("FAIL rand_busy cycle=%0d got=%b exp=%b", c, busy, m_clear); end
            checks++; if (at_max !== (m_count == MAXV) || at_zero !== (m_count == 0)) begin
                errors++; $display("FAIL rand_flags cycle=%0d got=%b%b exp=%b%b", c, at_max, at_zero, m_count == MAXV, m_count == 0);
            end
        end
        clr = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotate();
        test_saturate();
        test_zero();
        test_clear();
        test_async_reset();
`ifdef COUNTER_SCHED_WATERMARK_EN
        test_watermark();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
Round-robin scheduler that shares one WIDTH-bit up/down counter between NUM_REQ requesters. Each requester issues single-step increment or decrement requests over a valid/ready handshake. The block grants at most one request per cycle, masks requests that would overflow or underflow, and supports a synchronous clear. It sits between client logic and the shared occupancy/credit count.

Parameters:
- WIDTH, 8, counter width in bits.
- NUM_REQ, 4, number of requesters (≥2).
- MAX_VAL, 2**WIDTH-1, upper saturation limit; must be ≤ 2**WIDTH-1 and ≥1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_dir  in  NUM_REQ  per-requester direction; 1 = increment, 0 = decrement. Must be stable while req_valid is high.
- req_ready  out  NUM_REQ  one-hot grant; a transfer happens when req_valid[i] & req_ready[i].
- clr  in  1  synchronous clear request, single-cycle pulse or level.
- count  out  WIDTH  current counter value, registered.
- busy  out  1  high while state is CLEAR.
- at_max  out  1  registered, count == MAX_VAL.
- at_zero  out  1  registered, count == 0.

Behaviour:
- Reset, asynchronous and active-high:
  - count = 0, at_zero = 1, at_max = 0, busy = 0.
  - State = IDLE; RR pointer = 0.
  - req_ready is combinational and evaluates to 0 during reset.
- Eligibility:
  - Requester i is eligible when req_valid[i] is high and the step is legal.
  - Increment is legal only when count < MAX_VAL; decrement only when count > 0.
  - Ineligible requests stay pending, are never granted, and are never dropped.
- Arbitration:
  - Round-robin among eligible requesters, starting at the RR pointer.
  - req_ready is one-hot or all-zero, combinational from registered state and current req_valid/req_dir.
  - On each grant, the pointer moves to (granted index + 1) mod NUM_REQ; otherwise it holds.
- Latency: count updates on the clock edge that completes the transfer, so the new value is visible the next cycle. Maximum throughput is 1 step per cycle.
- Arithmetic: ±1 only, never wraps; saturation is enforced by eligibility masking. at_max and at_zero are derived from the next count value and registered with it.
- FSM states:
  - IDLE: no eligible request. Goes to ACTIVE when any request is eligible, or to CLEAR when clr is high.
  - ACTIVE: grants are issued. Goes to IDLE when no request is eligible, or to CLEAR when clr is high.
  - CLEAR: lasts exactly one cycle; req_ready = 0, busy = 1, count ← 0 at exit. Then goes to IDLE.
- clr priority: clr in IDLE or ACTIVE suppresses the same-cycle grant (req_ready = 0) and moves to CLEAR. If clr is held high, CLEAR re-enters every cycle.
- Simultaneous events:
  - Competing increment and decrement requests are arbitrated normally; there is no netting.
  - At count == MAX_VAL, only decrementers can be granted; at count == 0, only incrementers.
- Reset mid-transfer: the transfer is abandoned, count returns to 0, and pending requests are re-arbitrated from pointer 0 after reset.

Optional Feature:
- Macro: COUNTER_SCHED_WATERMARK_EN.
- Defined:
  - Adds inputs hi_wm[WIDTH] and lo_wm[WIDTH], and output wm_irq.
  - wm_irq is a one-cycle registered pulse when count crosses upward to ≥ hi_wm, or downward to ≤ lo_wm.
  - wm_irq resets to 0 and does not fire on clr.
- Undefined: no extra ports or logic; wm_irq is absent.

Decomposition:
- Package counter_sched_pkg:
  - state enum {IDLE, ACTIVE, CLEAR} (2 bits).
  - Direction constants DIR_INC = 1'b1, DIR_DEC = 1'b0.
- Sub-module rr_arb (parameter N):
  - Inputs: eligible vector, pointer.
  - Outputs: one-hot grant, next pointer.
  - Purely combinational; pointer register stays in counter_sched.

Test Plan:
1. Reset, then requester 2 asserts increment for 5 cycles, no others → req_ready = 0100 each cycle; count reads 1..5; at_zero drops after the first step.
2. All 4 requesters request increment continuously from count 0 → grants rotate 0,1,2,3,0,…; count reaches 8 after 8 cycles; each requester is granted exactly twice.
3. WIDTH=4, MAX_VAL=10, count = 10; requester 0 increments and requester 1 decrements → only requester 1 is granted; count = 9; requester 0 is granted the following cycle and count returns to 10.
4. count = 0, requester 3 decrements only → req_ready stays 0 and count stays 0 indefinitely. Then requester 1 increments → requester 1 is granted, count = 1, and requester 3 is granted next cycle, giving count = 0.
5. count = 7 with active requests; clr pulsed → that cycle req_ready = 0; next cycle busy = 1 and req_ready = 0; count = 0 the cycle after; arbitration resumes.
6. rst asserted asynchronously mid-burst at count = 3 → count = 0 immediately without a clock edge. With COUNTER_SCHED_WATERMARK_EN, hi_wm = 4, incrementing from 3 → wm_irq pulses once when count becomes 4.
